// File: rtl/vga_pkg.sv
// Shared video timing and sprite constants for the VGA sprite path.
// Also holds the coordinate clamp helper used when loading the shadow bank.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int SPR_W    = 32;
    localparam int SPR_H    = 32;

    localparam int SPR_P0   = 0;
    localparam int SPR_PU0  = 1;
    localparam int SPR_P1   = 2;
    localparam int SPR_PU1  = 3;

    localparam int NUM_SPR_DEF = 4;
    localparam int X_W_DEF     = 10;
    localparam int Y_W_DEF     = 9;
    localparam int X_MAX_DEF   = H_ACTIVE - SPR_W;
    localparam int Y_MAX_DEF   = V_ACTIVE - SPR_H;

    // Keep a sprite fully on screen: anything past the last legal origin pins to it.
    function automatic int clamp_coord(input int v, input int max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/sprite_update_scheduler_rr_arbiter.sv
// Round-robin picker: first eligible requester at or after rr_ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((32'(rr_ptr) + 32'(k)) % 32'(N));
            if (enable && !found && eligible[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/sprite_update_scheduler.sv
// Collects per-sprite position updates into a shadow bank and copies the dirty
// entries to the active bank once per frame on the falling edge of vs_n.
module sprite_update_scheduler
    import vga_pkg::*;
#(
    parameter int NUM_SPR = NUM_SPR_DEF,
    parameter int X_W     = X_W_DEF,
    parameter int Y_W     = Y_W_DEF,
    parameter int X_MAX   = X_MAX_DEF,
    parameter int Y_MAX   = Y_MAX_DEF
) (
    input  logic                   vga_clk,
    input  logic                   reset,
    input  logic                   vs_n,
    input  logic [NUM_SPR-1:0]     req,
    input  logic [NUM_SPR*X_W-1:0] req_x,
    input  logic [NUM_SPR*Y_W-1:0] req_y,
    output logic [NUM_SPR-1:0]     ack,
    output logic [NUM_SPR*X_W-1:0] spr_x,
    output logic [NUM_SPR*Y_W-1:0] spr_y,
    output logic                   commit,
    output logic [NUM_SPR-1:0]     commit_mask,
    output logic [15:0]            frame_cnt
);

    localparam int IDX_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

    logic                 vs_q;
    logic                 fall;
    logic [NUM_SPR-1:0]   ack_q, ack_d;
    logic                 commit_q, commit_d;
    logic [NUM_SPR-1:0]   commit_mask_q, commit_mask_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic [NUM_SPR-1:0]   dirty_q, dirty_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [X_W-1:0]       shadow_x_q [NUM_SPR];
    logic [X_W-1:0]       shadow_x_d [NUM_SPR];
    logic [Y_W-1:0]       shadow_y_q [NUM_SPR];
    logic [Y_W-1:0]       shadow_y_d [NUM_SPR];
    logic [X_W-1:0]       active_x_q [NUM_SPR];
    logic [X_W-1:0]       active_x_d [NUM_SPR];
    logic [Y_W-1:0]       active_y_q [NUM_SPR];
    logic [Y_W-1:0]       active_y_d [NUM_SPR];
    logic [X_W-1:0]       req_x_arr  [NUM_SPR];
    logic [Y_W-1:0]       req_y_arr  [NUM_SPR];
    logic [NUM_SPR-1:0]   eligible;
    logic [NUM_SPR-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPR; gi++) begin : g_pack
            assign req_x_arr[gi]            = req_x[gi*X_W +: X_W];
            assign req_y_arr[gi]            = req_y[gi*Y_W +: Y_W];
            assign spr_x[gi*X_W +: X_W]     = active_x_q[gi];
            assign spr_y[gi*Y_W +: Y_W]     = active_y_q[gi];
        end
    endgenerate

    assign fall        = vs_q & ~vs_n;
    // A sprite acked this cycle is still holding req; excluding it avoids a double grant.
    assign eligible    = req & ~ack_q;
    assign grant_valid = |grant;

    rr_arbiter #(
        .N     (NUM_SPR),
        .IDX_W (IDX_W)
    ) u_arb (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr_q),
        .enable    (~fall),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        ack_d         = '0;
        commit_d      = 1'b0;
        commit_mask_d = '0;
        frame_cnt_d   = frame_cnt_q;
        dirty_d       = dirty_q;
        rr_ptr_d      = rr_ptr_q;
        shadow_x_d    = shadow_x_q;
        shadow_y_d    = shadow_y_q;
        active_x_d    = active_x_q;
        active_y_d    = active_y_q;

        if (grant_valid) begin
            shadow_x_d[grant_idx] = X_W'(clamp_coord(int'(req_x_arr[grant_idx]), X_MAX));
            shadow_y_d[grant_idx] = Y_W'(clamp_coord(int'(req_y_arr[grant_idx]), Y_MAX));
            dirty_d[grant_idx]    = 1'b1;
            ack_d                 = grant;
            rr_ptr_d              = IDX_W'((32'(grant_idx) + 32'd1) % 32'(NUM_SPR));
        end

        // Grants are frozen in the fall cycle, so the commit never races a shadow write.
        if (fall) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                if (dirty_q[i]) begin
                    active_x_d[i] = shadow_x_q[i];
                    active_y_d[i] = shadow_y_q[i];
                end
            end
            commit_d      = 1'b1;
            commit_mask_d = dirty_q;
            dirty_d       = '0;
            frame_cnt_d   = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            vs_q          <= 1'b1;
            ack_q         <= '0;
            commit_q      <= 1'b0;
            commit_mask_q <= '0;
            frame_cnt_q   <= '0;
            dirty_q       <= '0;
            rr_ptr_q      <= '0;
            for (int i = 0; i < NUM_SPR; i++) begin
                shadow_x_q[i] <= '0;
                shadow_y_q[i] <= '0;
                active_x_q[i] <= '0;
                active_y_q[i] <= '0;
            end
        end else begin
            vs_q          <= vs_n;
            ack_q         <= ack_d;
            commit_q      <= commit_d;
            commit_mask_q <= commit_mask_d;
            frame_cnt_q   <= frame_cnt_d;
            dirty_q       <= dirty_d;
            rr_ptr_q      <= rr_ptr_d;
            shadow_x_q    <= shadow_x_d;
            shadow_y_q    <= shadow_y_d;
            active_x_q    <= active_x_d;
            active_y_q    <= active_y_d;
        end
    end

    assign ack         = ack_q;
    assign commit      = commit_q;
    assign commit_mask = commit_mask_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/sprite_update_scheduler.md
Name: sprite_update_scheduler

Overview:
- Frame-synchronous scheduler between game logic and the VGA sprite-compare datapath.
- Accepts position updates for 4 sprites (player0, powerup0, player1, powerup1) over per-sprite req/ack handshakes and arbitrates them round-robin into a shadow bank.
- Commits dirty shadow entries to the active bank once per frame, at the start of vertical sync, so sprites never tear mid-frame.
- Active-bank outputs drive the renderer's sprite X/Y compare registers directly.

Parameters:
- NUM_SPR, 4, number of sprite slots/requesters (fixed at 4 for this revision).
- X_W, 10, X coordinate width.
- Y_W, 9, Y coordinate width.
- X_MAX, 608, largest legal sprite X (H_ACTIVE 640 - SPR_W 32).
- Y_MAX, 448, largest legal sprite Y (V_ACTIVE 480 - SPR_H 32).

Ports:
- vga_clk  in  1  pixel clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- vs_n  in  1  active-low vertical sync from video_sync_generator.
- req  in  NUM_SPR  per-sprite update request; bit i = sprite i.
- req_x  in  NUM_SPR*X_W  requested X; slot i at [i*X_W +: X_W].
- req_y  in  NUM_SPR*Y_W  requested Y; slot i at [i*Y_W +: Y_W].
- ack  out  NUM_SPR  registered one-cycle acknowledge per sprite.
- spr_x  out  NUM_SPR*X_W  active-bank X, same packing.
- spr_y  out  NUM_SPR*Y_W  active-bank Y, same packing.
- commit  out  1  one-cycle pulse when the active bank is updated.
- commit_mask  out  NUM_SPR  sprites updated by the current commit; valid while commit=1, 0 otherwise.
- frame_cnt  out  16  count of vs_n falling edges; wraps.

Behaviour:
- Reset (async, asynchronous assert): ack, commit, commit_mask, frame_cnt, shadow, active, dirty and rr pointer all 0; vs_q = 1.
- Edge detect:
  - vs_q <= vs_n every cycle.
  - fall = vs_q & ~vs_n (combinational).
- Arbitration (cycle t):
  - eligible = req & ~ack.
  - A requester whose ack is high is excluded, so a held req is never double-granted.
  - If fall = 1, no grant in this cycle (commit cycle freeze).
  - Otherwise, grant the first eligible index starting at rr_ptr, wrapping.
  - At most one grant per cycle.
- On grant g at edge t+1:
  - shadow[g] <= clamp(req_x[g], req_y[g]).
  - dirty[g] <= 1.
  - ack[g] <= 1 (ack high for the whole of cycle t+1).
  - rr_ptr <= (g+1) mod NUM_SPR.
  - Other ack bits <= 0.
  - With no grant, all ack bits <= 0 and rr_ptr holds.
- Handshake:
  - Requester holds req and data stable until it samples ack = 1, then drops req or presents new data.
  - req still high in the cycle after ack is treated as a new request.
- Latency: uncontested request, no fall, gives ack exactly 1 cycle after req is first seen. With k contenders ahead in RR order, latency is k+1 cycles.
- Clamp:
  - x > X_MAX gives x = X_MAX; y > Y_MAX gives y = Y_MAX; otherwise unchanged.
  - Compare is unsigned at full port width.
- Commit (edge after a cycle with fall = 1):
  - For each i with dirty[i] = 1: active[i] <= shadow[i].
  - commit <= 1; commit_mask <= dirty; dirty <= 0.
  - frame_cnt <= frame_cnt + 1, wrapping 0xFFFF to 0.
  - commit is pulsed even when dirty = 0 (commit_mask = 0).
  - In the next cycle: commit <= 0 and commit_mask <= 0.
- Simultaneous events:
  - A request pending during the fall cycle waits one cycle and lands in the shadow bank for the next frame.
  - Two updates to the same sprite within one frame: the last one wins.
- Reset mid-operation:
  - Outstanding requests are dropped with no ack.
  - A requester still holding req is granted normally after reset release.
  - Active bank returns to (0,0).
- vs_n held low for many cycles causes only one commit; the next commit requires vs_n to return high.

Decomposition:
- vga_pkg holds shared constants: H_ACTIVE = 640, V_ACTIVE = 480, SPR_W = 32, SPR_H = 32, and sprite index constants SPR_P0 = 0, SPR_PU0 = 1, SPR_P1 = 2, SPR_PU1 = 3.
- Sub-module rr_arbiter: inputs eligible, rr_ptr, enable; outputs one-hot grant and an index.
- Remaining logic (shadow/active banks, dirty, clamp, commit, counters) stays in sprite_update_scheduler.

Test Plan:
- Reset release, vs_n high, no req -> spr_x/spr_y all 0, ack = 0, commit = 0, frame_cnt = 0.
- req[0] with (100,200), release on ack; then drive vs_n 1->0 -> ack[0] high exactly 1 cycle after req; spr_x[0] = 100 and spr_y[0] = 200 one edge after the fall cycle; commit = 1 with commit_mask = 4'b0001; frame_cnt = 1.
- req = 4'b1111 asserted together, rr_ptr = 0, each requester releasing on its ack -> acks in order 0,1,2,3 on consecutive cycles; a second burst starting with rr_ptr = 0 repeats the 0..3 order.
- req[2] with (700,500) -> after commit, spr_x[2] = 608 and spr_y[2] = 448.
- req[1] asserted in the same cycle vs_n falls -> no ack that cycle; ack the next cycle; commit_mask = 0; spr_x[1] unchanged until the following frame's commit.
- Async reset asserted mid-frame with dirty = 4'b0101 -> outputs 0 immediately; next vs_n fall gives commit = 1 with commit_mask = 0 and frame_cnt = 1.
